// File: rtl/mbist_comparator_pkg.sv
// -----------------------------------------------------------------------------
// mbist_pkg
// Shared definitions for the MBIST slice: the controller, the pattern mux and
// the read-data comparator all import this package.
//   - default widths / read latency used as parameter defaults
//   - mbist_state_e : comparator sequencing states
//   - drain_last()  : terminal value of the DRAIN cycle counter
// -----------------------------------------------------------------------------
package mbist_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int MAX_RD_LAT     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mbist_state_e;

  // DRAIN lasts rd_lat cycles; the counter starts at 0 on entry.
  function automatic logic [2:0] drain_last(input int rd_lat);
    return 3'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/mbist_comparator_if.sv
// -----------------------------------------------------------------------------
// mbist_comparator_if
// Bus between the MBIST controller / pattern mux / SRAM and the comparator.
//   controller side (master) drives : start, cmp_en, test_end, addr,
//                                     exp_data, rd_data
//   comparator side (slave) drives  : busy, done, pass, fail, fail_count,
//                                     first_fail_addr, first_fail_syn
// -----------------------------------------------------------------------------
interface mbist_comparator_if
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();

  logic                  start;
  logic                  cmp_en;
  logic                  test_end;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  fail;
  logic [CNT_WIDTH-1:0]  fail_count;
  logic [ADDR_WIDTH-1:0] first_fail_addr;
  logic [DATA_WIDTH-1:0] first_fail_syn;

  modport master (
    output start, cmp_en, test_end, addr, exp_data, rd_data,
    input  busy, done, pass, fail, fail_count, first_fail_addr, first_fail_syn
  );

  modport slave (
    input  start, cmp_en, test_end, addr, exp_data, rd_data,
    output busy, done, pass, fail, fail_count, first_fail_addr, first_fail_syn
  );

endinterface

// File: rtl/mbist_comparator_delay_line.sv
// -----------------------------------------------------------------------------
// mbist_delay_line
// DEPTH-stage shift register that aligns a read request (valid/addr/expected
// word) with the SRAM data returning DEPTH cycles later.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears every stage
//   flush : synchronous clear of every stage (new test started)
//   din   : request payload entering stage 0
//   dout  : payload leaving the last stage
// -----------------------------------------------------------------------------
module mbist_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // NOTE: combinational blocks use blocking '=' and assign every element on
  // every pass, so no latch can be inferred.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all stages sample the
  // pre-edge values and shift together.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // NOTE: this array is a handful of pipeline flops, not a RAM, so it is
      // cleared; a stale valid must never reach the comparator.
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mbist_comparator.sv
// -----------------------------------------------------------------------------
// mbist_comparator
// Compares SRAM read data against the expected pattern RD_LAT cycles after each
// read is issued, and keeps a sticky pass/fail summary for one MBIST run.
//
// Ports
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mbist_comparator_if.slave
//         in : start, cmp_en, test_end, addr, exp_data, rd_data
//         out: busy, done, pass, fail, fail_count (saturating),
//              first_fail_addr, first_fail_syn (exp ^ rd of first mismatch)
//
// Build option
//   MBIST_CMP_DIAG_EN : when defined, the address and syndrome of the first
//                       mismatch are captured; otherwise both outputs are tied
//                       to 0 and carry no storage.
//
// Sequencing: IDLE -start-> RUN -test_end-> DRAIN -(RD_LAT cycles)-> DONE
//             -start-> RUN.  start from any state restarts the run.
// -----------------------------------------------------------------------------
module mbist_comparator
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LAT     = DEF_RD_LAT,     // legal 1..MAX_RD_LAT
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  mbist_comparator_if.slave bus
);

`ifdef MBIST_CMP_DIAG_EN
  localparam int PAY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
`else
  localparam int PAY_W = 1 + DATA_WIDTH;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mbist_state_e          state_q, state_d;
  logic [2:0]            drain_cnt_q, drain_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;

  // ---------------------------------------------------------------------------
  // Request delay line
  // ---------------------------------------------------------------------------
  // Reads are only accepted while RUN (the test_end cycle included); start
  // flushes anything in flight so an old mismatch cannot leak into a new run.
  logic                  cap_valid;
  logic [PAY_W-1:0]      pipe_in;
  logic [PAY_W-1:0]      pipe_out;
  logic                  valid_dly;
  logic [DATA_WIDTH-1:0] exp_dly;

  assign cap_valid = bus.cmp_en && (state_q == ST_RUN);

`ifdef MBIST_CMP_DIAG_EN
  logic [ADDR_WIDTH-1:0] addr_dly;
  assign pipe_in                      = {cap_valid, bus.addr, bus.exp_data};
  assign {valid_dly, addr_dly, exp_dly} = pipe_out;
`else
  // The read address only feeds first-fail capture.
  logic unused_addr;
  assign unused_addr           = ^bus.addr;
  assign pipe_in               = {cap_valid, bus.exp_data};
  assign {valid_dly, exp_dly}  = pipe_out;
`endif

  mbist_delay_line #(
    .WIDTH (PAY_W),
    .DEPTH (RD_LAT)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.start),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  // ---------------------------------------------------------------------------
  // Compare
  // ---------------------------------------------------------------------------
  logic                  mismatch;
  logic [DATA_WIDTH-1:0] syndrome;

  assign syndrome = exp_dly ^ bus.rd_data;
  assign mismatch = valid_dly && (syndrome != '0);

`ifdef MBIST_CMP_DIAG_EN
  logic [ADDR_WIDTH-1:0] first_fail_addr_q, first_fail_addr_d;
  logic [DATA_WIDTH-1:0] first_fail_syn_q, first_fail_syn_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-result logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    fail_d       = fail_q;
    fail_count_d = fail_count_q;
`ifdef MBIST_CMP_DIAG_EN
    first_fail_addr_d = first_fail_addr_q;
    first_fail_syn_d  = first_fail_syn_q;
`endif

    // Sequencing; start outranks test_end and the drain timeout.
    if (bus.start) begin
      state_d     = ST_RUN;
      drain_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN: begin
          if (bus.test_end) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
        ST_DRAIN: begin
          // The last read needs RD_LAT cycles to return; its result registers
          // on the same edge that enters DONE.
          if (drain_cnt_q == drain_last(RD_LAT)) begin
            state_d = ST_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + 3'd1;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Results: start clears, otherwise accumulate mismatches.
    if (bus.start) begin
      fail_d       = 1'b0;
      fail_count_d = '0;
`ifdef MBIST_CMP_DIAG_EN
      first_fail_addr_d = '0;
      first_fail_syn_d  = '0;
`endif
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (fail_count_q != '1) begin
        fail_count_d = fail_count_q + 1'b1;
      end
`ifdef MBIST_CMP_DIAG_EN
      if (!fail_q) begin
        first_fail_addr_d = addr_dly;
        first_fail_syn_d  = syndrome;
      end
`endif
    end

    // Status outputs are registered from the next state.
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && !fail_d;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
    end
  end

`ifdef MBIST_CMP_DIAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      first_fail_addr_q <= '0;
      first_fail_syn_q  <= '0;
    end else begin
      first_fail_addr_q <= first_fail_addr_d;
      first_fail_syn_q  <= first_fail_syn_d;
    end
  end

  assign bus.first_fail_addr = first_fail_addr_q;
  assign bus.first_fail_syn  = first_fail_syn_q;
`else
  assign bus.first_fail_addr = '0;
  assign bus.first_fail_syn  = '0;
`endif

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_mbist_comparator.sv
// -----------------------------------------------------------------------------
// tb_mbist_comparator
// Three comparators share one stimulus stream:
//   dut 0 : RD_LAT=1, CNT_WIDTH=8
//   dut 1 : RD_LAT=3, CNT_WIDTH=8
//   dut 2 : RD_LAT=2, CNT_WIDTH=4
// Each sees read data from a small SRAM model with its own read latency.
// Expected first-fail values depend on whether MBIST_CMP_DIAG_EN is defined.
// -----------------------------------------------------------------------------
module tb_mbist_comparator;

`ifdef MBIST_CMP_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  localparam int N_DUT = 3;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 2;
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 2) ? 15 : 255;
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cmp_en = 1'b0;
  logic       test_end = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] exp_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // SRAM model: combinational array read through per-DUT address pipelines
  // ---------------------------------------------------------------------------
  logic [7:0] mem [256];
  logic [7:0] pipe_a = '0;
  logic [7:0] pipe_b [3] = '{default: '0};
  logic [7:0] pipe_c [2] = '{default: '0};

  always @(posedge clk) begin
    pipe_a    <= addr;
    pipe_b[0] <= addr;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    pipe_c[0] <= addr;
    pipe_c[1] <= pipe_c[0];
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  mbist_comparator_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(8)) if_a ();
  mbist_comparator_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(8)) if_b ();
  mbist_comparator_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(4)) if_c ();

  assign if_a.start = start;    assign if_b.start = start;    assign if_c.start = start;
  assign if_a.cmp_en = cmp_en;  assign if_b.cmp_en = cmp_en;  assign if_c.cmp_en = cmp_en;
  assign if_a.test_end = test_end;
  assign if_b.test_end = test_end;
  assign if_c.test_end = test_end;
  assign if_a.addr = addr;      assign if_b.addr = addr;      assign if_c.addr = addr;
  assign if_a.exp_data = exp_data;
  assign if_b.exp_data = exp_data;
  assign if_c.exp_data = exp_data;
  assign if_a.rd_data = mem[pipe_a];
  assign if_b.rd_data = mem[pipe_b[2]];
  assign if_c.rd_data = mem[pipe_c[1]];

  mbist_comparator #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LAT(1), .CNT_WIDTH(8))
    u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mbist_comparator #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LAT(3), .CNT_WIDTH(8))
    u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
  mbist_comparator #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LAT(2), .CNT_WIDTH(4))
    u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // Observed outputs gathered per DUT index
  logic       busy_v [N_DUT];
  logic       done_v [N_DUT];
  logic       pass_v [N_DUT];
  logic       fail_v [N_DUT];
  logic [7:0] cnt_v  [N_DUT];
  logic [7:0] ffa_v  [N_DUT];
  logic [7:0] ffs_v  [N_DUT];

  assign busy_v[0] = if_a.busy;  assign busy_v[1] = if_b.busy;  assign busy_v[2] = if_c.busy;
  assign done_v[0] = if_a.done;  assign done_v[1] = if_b.done;  assign done_v[2] = if_c.done;
  assign pass_v[0] = if_a.pass;  assign pass_v[1] = if_b.pass;  assign pass_v[2] = if_c.pass;
  assign fail_v[0] = if_a.fail;  assign fail_v[1] = if_b.fail;  assign fail_v[2] = if_c.fail;
  assign cnt_v[0]  = if_a.fail_count;
  assign cnt_v[1]  = if_b.fail_count;
  assign cnt_v[2]  = {4'h0, if_c.fail_count};
  assign ffa_v[0]  = if_a.first_fail_addr;
  assign ffa_v[1]  = if_b.first_fail_addr;
  assign ffa_v[2]  = if_c.first_fail_addr;
  assign ffs_v[0]  = if_a.first_fail_syn;
  assign ffs_v[1]  = if_b.first_fail_syn;
  assign ffs_v[2]  = if_c.first_fail_syn;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int d, input bit e_busy,
                               input bit e_done, input bit e_fail, input int e_cnt,
                               input logic [7:0] e_ffa, input logic [7:0] e_ffs);
    check($sformatf("%s busy[%0d]", tag, d), 32'(busy_v[d]), 32'(e_busy));
    check($sformatf("%s done[%0d]", tag, d), 32'(done_v[d]), 32'(e_done));
    check($sformatf("%s pass[%0d]", tag, d), 32'(pass_v[d]), 32'(e_done && !e_fail));
    check($sformatf("%s fail[%0d]", tag, d), 32'(fail_v[d]), 32'(e_fail));
    check($sformatf("%s cnt[%0d]",  tag, d), 32'(cnt_v[d]),  32'(e_cnt));
    check($sformatf("%s ffa[%0d]",  tag, d), 32'(ffa_v[d]),  32'(DIAG ? e_ffa : 8'h00));
    check($sformatf("%s ffs[%0d]",  tag, d), 32'(ffs_v[d]),  32'(DIAG ? e_ffs : 8'h00));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] e);
    cmp_en   = 1'b1;
    addr     = a;
    exp_data = e;
    tick();
    cmp_en   = 1'b0;
  endtask

  // Pulse test_end (optionally with a last read), follow the drain cycle by
  // cycle, then check the final result of every DUT.
  task automatic end_and_check(input string tag, input bit last_read, input logic [7:0] la,
                               input bit e_fail, input int n_mis,
                               input logic [7:0] e_ffa, input logic [7:0] e_ffs);
    test_end = 1'b1;
    if (last_read) begin
      cmp_en   = 1'b1;
      addr     = la;
      exp_data = 8'h55;
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      test_end = 1'b0;
      cmp_en   = 1'b0;
      for (int d = 0; d < N_DUT; d++) begin
        check($sformatf("%s drain done[%0d] k=%0d", tag, d, k), 32'(done_v[d]),
              32'(k >= lat_of(d) + 1));
        check($sformatf("%s drain busy[%0d] k=%0d", tag, d, k), 32'(busy_v[d]),
              32'(k <= lat_of(d)));
        if (last_read) begin
          check($sformatf("%s late fail[%0d] k=%0d", tag, d, k), 32'(fail_v[d]),
                32'(k >= lat_of(d) + 1));
        end
      end
    end
    for (int d = 0; d < N_DUT; d++) begin
      check_outputs(tag, d, 1'b0, 1'b1, e_fail,
                    (n_mis > cmax_of(d)) ? cmax_of(d) : n_mis, e_ffa, e_ffs);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h55;

    // Reset state
    tick();
    tick();
    for (int d = 0; d < N_DUT; d++) check_outputs("rst", d, 0, 0, 0, 0, 8'h00, 8'h00);
    rst = 1'b0;
    tick();
    for (int d = 0; d < N_DUT; d++) check_outputs("idle", d, 0, 0, 0, 0, 8'h00, 8'h00);

    // 16 matching reads -> pass
    do_start();
    for (int d = 0; d < N_DUT; d++) check_outputs("run", d, 1, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) do_read(8'(i), 8'h55);
    end_and_check("clean", 1'b0, 8'h00, 1'b0, 0, 8'h00, 8'h00);

    // Single mismatch at 0x09: 0x57 vs 0x55, fail rises RD_LAT+1 after issue
    mem[9] = 8'h57;
    do_start();
    for (int i = 0; i < 16; i++) begin
      do_read(8'(i), 8'h55);
      for (int d = 0; d < N_DUT; d++) begin
        check($sformatf("single fail[%0d] i=%0d", d, i), 32'(fail_v[d]),
              32'(i >= 9 + lat_of(d)));
      end
    end
    end_and_check("single", 1'b0, 8'h00, 1'b1, 1, 8'h09, 8'h02);

    // Results hold in DONE: cmp_en and test_end there are ignored
    cmp_en   = 1'b1;
    addr     = 8'h09;
    exp_data = 8'h55;
    tick();
    test_end = 1'b1;
    tick();
    test_end = 1'b0;
    tick();
    cmp_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int d = 0; d < N_DUT; d++) check_outputs("hold", d, 0, 1, 1, 1, 8'h09, 8'h02);

    // Two mismatches: first stays at 0x03
    mem[9] = 8'h55;
    mem[3] = 8'h54;
    mem[7] = 8'h75;
    do_start();
    for (int i = 0; i < 16; i++) do_read(8'(i), 8'h55);
    end_and_check("double", 1'b0, 8'h00, 1'b1, 2, 8'h03, 8'h01);

    // 20 mismatches: 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) mem[i] = 8'hAA;
    do_start();
    for (int i = 0; i < 20; i++) do_read(8'(i), 8'h55);
    end_and_check("sat", 1'b0, 8'h00, 1'b1, 20, 8'h00, 8'hFF);

    // Mismatch on the read issued with test_end, resolved during DRAIN
    for (int i = 0; i < 20; i++) mem[i] = 8'h55;
    mem[8'h20] = 8'h50;
    do_start();
    for (int i = 0; i < 4; i++) do_read(8'(i), 8'h55);
    end_and_check("lastrd", 1'b1, 8'h20, 1'b1, 1, 8'h20, 8'h05);

    // rst mid-RUN with mismatches still in flight
    do_start();
    for (int i = 0; i < 4; i++) do_read(8'h20, 8'h55);
    check("prerst fail[0]", 32'(fail_v[0]), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < N_DUT; d++) check_outputs("midrst", d, 0, 0, 0, 0, 8'h00, 8'h00);
    // cmp_en in IDLE is ignored; nothing stale surfaces
    cmp_en = 1'b1;
    addr   = 8'h20;
    tick();
    tick();
    cmp_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int d = 0; d < N_DUT; d++) check_outputs("postrst", d, 0, 0, 0, 0, 8'h00, 8'h00);

    // start mid-DRAIN flushes pending mismatches
    do_start();
    do_read(8'h20, 8'h55);
    test_end = 1'b1;
    cmp_en   = 1'b1;
    addr     = 8'h20;
    tick();
    test_end = 1'b0;
    cmp_en   = 1'b0;
    check("predrain fail[0]", 32'(fail_v[0]), 32'(1));
    do_start();
    for (int d = 0; d < N_DUT; d++) check_outputs("drainstart", d, 1, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    for (int d = 0; d < N_DUT; d++) check_outputs("flushed", d, 1, 0, 0, 0, 8'h00, 8'h00);
    end_and_check("restart", 1'b0, 8'h00, 1'b0, 0, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
